mesh_out_arbiter: RTL and testbench

//  Shares one mesh router output (terminal or inter-router link) between N_IN input FIFOs.

---
 rtl/mesh_out_arbiter.sv | 110 +++++++++++
 tb/tb_mesh_out_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mesh_out_arbiter.sv
// mesh_out_arbiter: shares one router output among N_IN input FIFOs, round-robin with bounded bursts; BDCST_PRIO_EN lets broadcast heads win arbitration.
// Latency: grant 1 cycle after pndng_in, push_out 1 cycle after pop; full_out stalls the granted source in place, no re-arbitration.
module mesh_out_arbiter #(
  parameter int         N_IN    = 4,
  parameter int         pckg_sz = 32,
  parameter int         BURST   = 4,
  parameter logic [7:0] bdcst   = {8{1'b1}}
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_IN-1:0]         pndng_in,
  input  logic [N_IN*pckg_sz-1:0] data_in,
  output logic [N_IN-1:0]         pop_out,
  input  logic                    full_out,
  output logic                    push_out,
  output logic [pckg_sz-1:0]      data_out,
  output logic [$clog2(N_IN)-1:0] grant_id,
  output logic                    busy,
  output logic [15:0]             pkt_cnt
);
  localparam int IW = $clog2(N_IN);
  localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;
`ifdef BDCST_PRIO_EN
  localparam bit PRIO_EN = 1'b1;
`else
  localparam bit PRIO_EN = 1'b0;
`endif

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state;
  logic [IW-1:0]      rr_ptr;
  logic [BW-1:0]      burst_cnt;
  logic [N_IN-1:0]    bc_req;
  logic [N_IN-1:0]    req;
  logic               win_vld;
  logic [IW-1:0]      win_id;
  logic [pckg_sz-1:0] gnt_dat;
  logic               pop_any;

  // Broadcast heads form a priority class; round-robin order still applies inside it.
  always_comb begin
    bc_req = '0;
    for (int i = 0; i < N_IN; i++)
      bc_req[i] = pndng_in[i] && (data_in[i*pckg_sz + pckg_sz - 1 -: 8] == bdcst);
    req = (PRIO_EN && (|bc_req)) ? bc_req : pndng_in;
  end

  // Scan from farthest to nearest so the source closest after rr_ptr is kept last.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    for (int k = N_IN; k >= 1; k--) begin
      if (req[(int'(rr_ptr) + k) % N_IN]) begin
        win_vld = 1'b1;
        win_id  = IW'((int'(rr_ptr) + k) % N_IN);
      end
    end
  end

  always_comb begin
    pop_out = '0;
    if (state == GRANT && pndng_in[grant_id] && !full_out)
      pop_out[grant_id] = 1'b1;
  end

  assign pop_any = |pop_out;
  assign gnt_dat = data_in[int'(grant_id)*pckg_sz +: pckg_sz];
  assign busy    = (state == GRANT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= IW'(N_IN - 1);
      burst_cnt <= '0;
      grant_id  <= '0;
      push_out  <= 1'b0;
      data_out  <= '0;
      pkt_cnt   <= '0;
    end else begin
      push_out <= 1'b0;
      if (push_out)
        pkt_cnt <= pkt_cnt + 16'd1;
      case (state)
        IDLE: begin
          if (win_vld) begin
            grant_id  <= win_id;
            burst_cnt <= '0;
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (pop_any) begin
            data_out  <= gnt_dat;
            push_out  <= 1'b1;
            burst_cnt <= burst_cnt + 1'b1;
            if (burst_cnt == BW'(BURST - 1)) begin
              state  <= IDLE;
              rr_ptr <= grant_id;
            end
          end else if (!pndng_in[grant_id]) begin
            state  <= IDLE;
            rr_ptr <= grant_id;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mesh_out_arbiter.sv
// Bench for mesh_out_arbiter: FIFO-model sources, push scoreboard, burst/stall/reset/priority and counter-wrap checks.
module tb_mesh_out_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- instance A: BURST=4, sources modelled as FIFOs ----------------
  logic         rst_a = 1'b1;
  logic [3:0]   pndng_a;
  logic [127:0] data_a;
  logic [3:0]   pop_a;
  logic         full_a = 1'b0;
  logic         push_a;
  logic [31:0]  dout_a;
  logic [1:0]   gnt_a;
  logic         busy_a;
  logic [15:0]  cnt_a;

  logic [31:0] fmem [4][64];
  int          wr_a [4];
  int          rd_a [4];
  logic        flush_a = 1'b0;
  logic [31:0] exp_q [$];

  mesh_out_arbiter #(.N_IN(4), .pckg_sz(32), .BURST(4)) u_a (
    .clk(clk), .reset(rst_a), .pndng_in(pndng_a), .data_in(data_a), .pop_out(pop_a),
    .full_out(full_a), .push_out(push_a), .data_out(dout_a), .grant_id(gnt_a),
    .busy(busy_a), .pkt_cnt(cnt_a));

  always_comb begin
    pndng_a = '0;
    data_a  = '0;
    for (int i = 0; i < 4; i++) begin
      pndng_a[i]        = (rd_a[i] != wr_a[i]);
      data_a[i*32 +: 32] = fmem[i][rd_a[i] % 64];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (flush_a)       rd_a[i] <= wr_a[i];
      else if (pop_a[i]) rd_a[i] <= rd_a[i] + 1;
    end
  end

  task automatic put(input int s, input logic [31:0] d);
    fmem[s][wr_a[s] % 64] = d;
    wr_a[s] = wr_a[s] + 1;
  endtask

  always @(negedge clk) begin
    logic [31:0] e;
    if (push_a) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hBAD0_BAD0;
      chk("a_push_data", dout_a, e);
    end
  end

  // ---------------- instance B: BURST=2, all sources always pending ----------------
  logic         rst_b = 1'b1;
  logic [3:0]   pndng_b = 4'b0000;
  logic [127:0] data_b;
  logic [3:0]   pop_b;
  logic         push_b;
  logic [31:0]  dout_b;
  logic [1:0]   gnt_b;
  logic         busy_b;
  logic [15:0]  cnt_b;
  logic [31:0]  q_b [$];
  int           n_push_b = 0;
  int           exp_g_b [13]    = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
  int           exp_busy_b [13] = '{1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 1};

  function automatic logic [31:0] pat_b(input int i);
    return 32'h2000_0000 + 32'(i) * 32'h0100_0001;
  endfunction

  mesh_out_arbiter #(.N_IN(4), .pckg_sz(32), .BURST(2)) u_b (
    .clk(clk), .reset(rst_b), .pndng_in(pndng_b), .data_in(data_b), .pop_out(pop_b),
    .full_out(1'b0), .push_out(push_b), .data_out(dout_b), .grant_id(gnt_b),
    .busy(busy_b), .pkt_cnt(cnt_b));

  always @(negedge clk) begin
    logic [31:0] e;
    if (push_b) begin
      n_push_b++;
      e = (q_b.size() != 0) ? q_b.pop_front() : 32'hBAD0_BAD0;
      chk("b_push_data", dout_b, e);
    end
  end

  // ---------------- instance W: single source streaming, for pkt_cnt wrap ----------------
  logic        rst_w = 1'b1;
  logic [1:0]  pop_w;
  logic        push_w;
  logic [31:0] dout_w;
  logic [0:0]  gnt_w;
  logic        busy_w;
  logic [15:0] cnt_w;

  mesh_out_arbiter #(.N_IN(2), .pckg_sz(32), .BURST(255)) u_w (
    .clk(clk), .reset(rst_w), .pndng_in(2'b01), .data_in(64'h0000_0000_5A5A_0001),
    .pop_out(pop_w), .full_out(1'b0), .push_out(push_w), .data_out(dout_w),
    .grant_id(gnt_w), .busy(busy_w), .pkt_cnt(cnt_w));

  initial begin
    for (int i = 0; i < 4; i++) begin
      wr_a[i] = 0;
      data_b[i*32 +: 32] = pat_b(i);
    end
    fork
      begin : wrap_proc
        logic [15:0] model;
        bit          seen_ffff;
        bit          wrapped;
        model = '0; seen_ffff = 1'b0; wrapped = 1'b0;
        tick(2);
        rst_w = 1'b0;
        for (int c = 0; c < 70000 && !wrapped; c++) begin
          @(negedge clk);
          if (model == 16'hFFFF && !seen_ffff) begin
            chk("w_cnt_ffff", cnt_w, 16'hFFFF);
            seen_ffff = 1'b1;
          end else if (seen_ffff && model == 16'h0000) begin
            chk("w_cnt_wrap", cnt_w, 16'h0000);
            wrapped = 1'b1;
          end
          if (push_w) model = model + 16'd1;
        end
        if (!wrapped) chk("w_wrap_timeout", {31'd0, wrapped}, 32'd1);
      end
      begin : main_proc
        // reset state
        tick(2);
        chk("rst_push", push_a, 0);
        chk("rst_pop", pop_a, 0);
        chk("rst_data", dout_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_cnt", cnt_a, 0);

        // single source 0 after reset release
        rst_a = 1'b0;
        put(0, 32'h1100_0001); exp_q.push_back(32'h1100_0001);
        tick(1);
        chk("t1_gnt", gnt_a, 0);
        chk("t1_busy", busy_a, 1);
        chk("t1_pop", pop_a, 4'b0001);
        tick(4);

        // mid-sim reset clears outputs immediately
        rst_a = 1'b1; #1;
        chk("mrst_data", dout_a, 0);
        chk("mrst_cnt", cnt_a, 0);
        chk("mrst_busy", busy_a, 0);
        tick(1);
        rst_a = 1'b0;

        // src2 burst of three
        for (int j = 0; j < 3; j++) begin
          put(2, 32'h3400_00A0 + 32'(j)); exp_q.push_back(32'h3400_00A0 + 32'(j));
        end
        for (int c = 1; c <= 3; c++) begin
          tick(1);
          chk("t2_pop", pop_a, 4'b0100);
          chk("t2_gnt", gnt_a, 2);
        end
        tick(1);
        chk("t2_pop_c4", pop_a, 4'b0000);
        chk("t2_busy_c4", busy_a, 1);
        tick(1);
        chk("t2_busy_c5", busy_a, 0);
        chk("t2_cnt", cnt_a, 3);

        // full_out stall on src1
        for (int j = 0; j < 3; j++) begin
          put(1, 32'h5600_00B0 + 32'(j)); exp_q.push_back(32'h5600_00B0 + 32'(j));
        end
        tick(1);
        full_a = 1'b1;
        for (int k = 0; k < 5; k++) begin
          #1;
          chk("t4_pop", pop_a, 0);
          chk("t4_push", push_a, 0);
          chk("t4_gnt", gnt_a, 1);
          tick(1);
        end
        full_a = 1'b0; #1;
        chk("t4_resume", pop_a, 4'b0010);
        tick(6);

        // reset during src3 burst
        for (int j = 0; j < 4; j++) begin
          put(3, 32'h7800_00C0 + 32'(j)); exp_q.push_back(32'h7800_00C0 + 32'(j));
        end
        tick(3);
        chk("t5_pop_pre", pop_a, 4'b1000);
        chk("t5_push_pre", push_a, 1);
        rst_a = 1'b1; #1;
        chk("t5_push", push_a, 0);
        chk("t5_pop", pop_a, 0);
        chk("t5_busy", busy_a, 0);
        chk("t5_q", exp_q.size(), 3);
        exp_q.delete();
        flush_a = 1'b1;
        tick(1);
        flush_a = 1'b0;
        rst_a = 1'b0;
        for (int s = 0; s < 4; s++) begin
          put(s, 32'h9A00_00D0 + 32'(s)); exp_q.push_back(32'h9A00_00D0 + 32'(s));
        end
        tick(1);
        chk("t5_gnt", gnt_a, 0);
        chk("t5_busy2", busy_a, 1);
        tick(14);

        // broadcast priority with rr_ptr=3
        put(1, 32'h1200_00E1);
        put(3, 32'hFF00_00E3);
`ifdef BDCST_PRIO_EN
        exp_q.push_back(32'hFF00_00E3); exp_q.push_back(32'h1200_00E1);
        tick(1);
        chk("t6_gnt", gnt_a, 3);
`else
        exp_q.push_back(32'h1200_00E1); exp_q.push_back(32'hFF00_00E3);
        tick(1);
        chk("t6_gnt", gnt_a, 1);
`endif
        tick(8);
        chk("t6_q_empty", exp_q.size(), 0);
        chk("t6_cnt", cnt_a, 6);

        // BURST=2 round robin with all sources pending
        for (int g = 0; g < 4; g++) begin
          q_b.push_back(pat_b(g)); q_b.push_back(pat_b(g));
        end
        rst_b = 1'b0;
        pndng_b = 4'b1111;
        for (int c = 0; c < 13; c++) begin
          tick(1);
          chk("t3_gnt", gnt_b, exp_g_b[c]);
          chk("t3_busy", busy_b, exp_busy_b[c]);
        end
        chk("t3_npush", n_push_b, 8);
        rst_b = 1'b1; #1;
        chk("t3_q_empty", q_b.size(), 0);
      end
    join
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
